// File: rtl/reg_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Contents:
//   DATA_WIDTH / ADDR_WIDTH / CNT_W - default widths used by the top and scoreboard
//   req_id_e                        - requester identifiers (ALU = 0, load unit = 1)
//   REG_ZERO                        - hard-wired zero register index
package reg_wb_arbiter_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int CNT_W      = 2;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard for RAW hazard detection.
// Ports:
//   clk_i, rst_n_i        - clock / asynchronous active-low reset
//   issue_valid_i         - issue stage wants to reserve issue_waddr_i
//   issue_waddr_i         - destination being reserved
//   issue_ready_o         - reservation can be accepted this cycle
//   rf_wen_i, rf_waddr_i  - registered regfile write (retires one pending write)
//   raddr1_i, raddr2_i    - source addresses under test
//   busy1_o, busy2_o      - source has at least one pending write
module reg_scoreboard #(
    parameter int ADDR_WIDTH = reg_wb_arbiter_pkg::ADDR_WIDTH,
    parameter int CNT_W      = reg_wb_arbiter_pkg::CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_waddr_i,
    output logic                  issue_ready_o,
    input  logic                  rf_wen_i,
    input  logic [ADDR_WIDTH-1:0] rf_waddr_i,
    input  logic [ADDR_WIDTH-1:0] raddr1_i,
    input  logic [ADDR_WIDTH-1:0] raddr2_i,
    output logic                  busy1_o,
    output logic                  busy2_o
);

    import reg_wb_arbiter_pkg::*;

    localparam int               NREG     = 2 ** ADDR_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic             dec_s;
    logic             dec_hit_s;
    logic             inc_s;
    logic             issue_ready_s;
    logic [NREG-1:0]  inc_vec_s;
    logic [NREG-1:0]  dec_vec_s;

    // Reservation acceptance: a saturated counter only frees up if that register retires now.
    always_comb begin
        dec_s     = rf_wen_i && (rf_waddr_i != ZERO_ADDR);
        dec_hit_s = dec_s && (rf_waddr_i == issue_waddr_i);
        if (issue_waddr_i == ZERO_ADDR) begin
            issue_ready_s = 1'b1;
        end else if (cnt_q[issue_waddr_i] != CNT_MAX) begin
            issue_ready_s = 1'b1;
        end else begin
            issue_ready_s = dec_hit_s;
        end
        inc_s = issue_valid_i && issue_ready_s && (issue_waddr_i != ZERO_ADDR);
        inc_vec_s = '0;
        dec_vec_s = '0;
        if (inc_s) begin
            inc_vec_s[issue_waddr_i] = 1'b1;
        end else begin
            inc_vec_s = '0;
        end
        if (dec_s) begin
            dec_vec_s[rf_waddr_i] = 1'b1;
        end else begin
            dec_vec_s = '0;
        end
    end

    // Counter array: reserve increments, retire decrements, both together cancel.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int a = 0; a < NREG; a++) begin
                cnt_q[a] <= '0;
            end
        end else begin
            for (int a = 0; a < NREG; a++) begin
                case ({inc_vec_s[a], dec_vec_s[a]})
                    2'b10: begin
                        if (cnt_q[a] != CNT_MAX) cnt_q[a] <= cnt_q[a] + CNT_ONE;
                        else                     cnt_q[a] <= cnt_q[a];
                    end
                    2'b01: begin
                        // Retiring an empty counter is a protocol error; clamp at zero.
                        if (cnt_q[a] != '0) cnt_q[a] <= cnt_q[a] - CNT_ONE;
                        else                cnt_q[a] <= '0;
                    end
                    default: cnt_q[a] <= cnt_q[a];
                endcase
            end
        end
    end

    assign issue_ready_o = issue_ready_s;
    assign busy1_o = (raddr1_i != ZERO_ADDR) && (cnt_q[raddr1_i] != '0);
    assign busy2_o = (raddr2_i != ZERO_ADDR) && (cnt_q[raddr2_i] != '0);

    reg_scoreboard_chk u_chk (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .dec_i          (dec_s),
        .dec_cnt_zero_i (cnt_q[rf_waddr_i] == '0)
    );

endmodule

// File: rtl/reg_scoreboard_chk.sv
// Protocol checker for the pending-write scoreboard.
// Ports:
//   clk_i          - clock, rising edge
//   rst_n_i        - asynchronous active-low reset
//   dec_i          - a register retire (decrement) happens this cycle
//   dec_cnt_zero_i - the counter being retired is already zero
module reg_scoreboard_chk (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic dec_i,
    input  logic dec_cnt_zero_i
);

    // A retire with nothing outstanding means the writeback side skipped a reservation.
    a_no_dec_at_zero: assert property (@(posedge clk_i) disable iff (!rst_n_i)
                                       !(dec_i && dec_cnt_zero_i))
        else $error("reg_scoreboard: retire of register with no pending write");

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// (requester 0) and the load unit (requester 1), plus a pending-write scoreboard.
// Ports:
//   clk, rst (async active-low)
//   alu_valid/alu_ready/alu_waddr/alu_wdata - ALU writeback handshake
//   mem_valid/mem_ready/mem_waddr/mem_wdata - load-unit writeback handshake
//   issue_valid/issue_waddr/issue_ready     - destination reservation from issue
//   rf_wen/rf_waddr/rf_wdata                - registered regfile write port
//   raddr1/raddr2, busy1/busy2              - RAW hazard query for both sources
module reg_wb_arbiter #(
    parameter int DATA_WIDTH = reg_wb_arbiter_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_wb_arbiter_pkg::ADDR_WIDTH,
    parameter int CNT_W      = reg_wb_arbiter_pkg::CNT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_waddr,
    input  logic [DATA_WIDTH-1:0] alu_wdata,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [ADDR_WIDTH-1:0] mem_waddr,
    input  logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_waddr,
    output logic                  issue_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  busy1,
    output logic                  busy2
);

    import reg_wb_arbiter_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    req_id_e               last_grant_q, last_grant_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic                  alu_ready_s, mem_ready_s;
    logic                  gnt_alu_s, gnt_mem_s;

    // Arbitration: a requester loses only when the other is valid and it won last time.
    always_comb begin
        alu_ready_s  = !(mem_valid && (last_grant_q == REQ_ALU));
        mem_ready_s  = !(alu_valid && (last_grant_q == REQ_MEM));
        gnt_alu_s    = alu_valid && alu_ready_s;
        gnt_mem_s    = mem_valid && mem_ready_s;
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        if (gnt_alu_s) begin
            // Writes to the zero register complete the handshake but never reach the regfile.
            rf_wen_d     = (alu_waddr != ZERO_ADDR);
            rf_waddr_d   = alu_waddr;
            rf_wdata_d   = alu_wdata;
            last_grant_d = REQ_ALU;
        end else if (gnt_mem_s) begin
            rf_wen_d     = (mem_waddr != ZERO_ADDR);
            rf_waddr_d   = mem_waddr;
            rf_wdata_d   = mem_wdata;
            last_grant_d = REQ_MEM;
        end else begin
            rf_wen_d     = 1'b0;
        end
    end

    // Output stage and round-robin pointer; reset favours the ALU on first contention.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= REQ_MEM;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
        end
    end

    assign alu_ready = alu_ready_s;
    assign mem_ready = mem_ready_s;
    assign rf_wen    = rf_wen_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_W      (CNT_W)
    ) u_scoreboard (
        .clk_i         (clk),
        .rst_n_i       (rst),
        .issue_valid_i (issue_valid),
        .issue_waddr_i (issue_waddr),
        .issue_ready_o (issue_ready),
        .rf_wen_i      (rf_wen_q),
        .rf_waddr_i    (rf_waddr_q),
        .raddr1_i      (raddr1),
        .raddr2_i      (raddr2),
        .busy1_o       (busy1),
        .busy2_o       (busy2)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed self-checking bench for reg_wb_arbiter.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_waddr, mem_waddr, issue_waddr, rf_waddr, raddr1, raddr2;
    logic [31:0] alu_wdata, mem_wdata, rf_wdata;
    logic        issue_valid, issue_ready, rf_wen, busy1, busy2;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk (clk), .rst (rst),
        .alu_valid (alu_valid), .alu_ready (alu_ready), .alu_waddr (alu_waddr), .alu_wdata (alu_wdata),
        .mem_valid (mem_valid), .mem_ready (mem_ready), .mem_waddr (mem_waddr), .mem_wdata (mem_wdata),
        .issue_valid (issue_valid), .issue_waddr (issue_waddr), .issue_ready (issue_ready),
        .rf_wen (rf_wen), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata),
        .raddr1 (raddr1), .raddr2 (raddr2), .busy1 (busy1), .busy2 (busy2)
    );

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic reserve(input logic [4:0] a);
        issue_valid = 1'b1;
        issue_waddr = a;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic test_reset;
        tick(); tick(); settle();
        total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== 38'd0) $display("FAIL reset_rf: got %0b/%0h/%0h want 0/0/0", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
        total_cnt++; if (issue_ready !== 1'b1) $display("FAIL reset_issue_ready: got %0b want 1", issue_ready); else pass_cnt++;
        total_cnt++; if ({alu_ready, mem_ready} !== 2'b11) $display("FAIL reset_ready: got %0b want 11", {alu_ready, mem_ready}); else pass_cnt++;
        for (int a = 0; a < 4; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(a + 8); settle();
            total_cnt++; if ({busy1, busy2} !== 2'b00) $display("FAIL reset_busy: raddr %0d got %0b want 00", a, {busy1, busy2}); else pass_cnt++;
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_contention;
        reserve(5'd3); reserve(5'd3); reserve(5'd4); reserve(5'd4);
        alu_valid = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h11;
        mem_valid = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'h22;
        settle();
        total_cnt++; if ({alu_ready, mem_ready} !== 2'b10) $display("FAIL cont_first_grant: got %0b want 10", {alu_ready, mem_ready}); else pass_cnt++;
        tick();
        total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) $display("FAIL cont_wr1: got %0b/%0d/%0h want 1/3/11", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
        settle();
        total_cnt++; if ({alu_ready, mem_ready} !== 2'b01) $display("FAIL cont_second_grant: got %0b want 01", {alu_ready, mem_ready}); else pass_cnt++;
        tick();
        total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h22}) $display("FAIL cont_wr2: got %0b/%0d/%0h want 1/4/22", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
        settle();
        total_cnt++; if ({alu_ready, mem_ready} !== 2'b10) $display("FAIL cont_third_grant: got %0b want 10", {alu_ready, mem_ready}); else pass_cnt++;
        tick();
        total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) $display("FAIL cont_wr3: got %0b/%0d/%0h want 1/3/11", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        total_cnt++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b0, 5'd3, 32'h11}) $display("FAIL cont_idle_hold: got %0b/%0d/%0h want 0/3/11", rf_wen, rf_waddr, rf_wdata); else pass_cnt++;
        raddr1 = 5'd3; raddr2 = 5'd4; settle();
        total_cnt++; if ({busy1, busy2} !== 2'b01) $display("FAIL cont_busy: got %0b want 01", {busy1, busy2}); else pass_cnt++;
    endtask

    task automatic test_zero_reg;
        alu_valid = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'hDEAD; settle();
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL zero_alu_ready: got %0b want 1", alu_ready); else pass_cnt++;
        tick();
        alu_valid = 1'b0;
        total_cnt++; if (rf_wen !== 1'b0) $display("FAIL zero_rf_wen: got %0b want 0", rf_wen); else pass_cnt++;
        issue_valid = 1'b1; issue_waddr = 5'd0; settle();
        total_cnt++; if (issue_ready !== 1'b1) $display("FAIL zero_issue_ready: got %0b want 1", issue_ready); else pass_cnt++;
        tick();
        issue_valid = 1'b0; raddr1 = 5'd0; settle();
        total_cnt++; if (busy1 !== 1'b0) $display("FAIL zero_busy: got %0b want 0", busy1); else pass_cnt++;
    endtask

    task automatic test_lifecycle;
        issue_valid = 1'b1; issue_waddr = 5'd5; raddr1 = 5'd5; settle();
        total_cnt++; if (busy1 !== 1'b0) $display("FAIL life_busy_c0: got %0b want 0", busy1); else pass_cnt++;
        tick();
        issue_valid = 1'b0; settle();
        total_cnt++; if (busy1 !== 1'b1) $display("FAIL life_busy_c1: got %0b want 1", busy1); else pass_cnt++;
        tick(); tick(); tick();
        alu_valid = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h55; settle();
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL life_grant_c4: got %0b want 1", alu_ready); else pass_cnt++;
        tick();
        alu_valid = 1'b0; settle();
        total_cnt++; if ({rf_wen, rf_waddr, rf_wdata, busy1} !== {1'b1, 5'd5, 32'h55, 1'b1}) $display("FAIL life_c5: got %0b/%0d/%0h busy %0b want 1/5/55 busy 1", rf_wen, rf_waddr, rf_wdata, busy1); else pass_cnt++;
        tick(); settle();
        total_cnt++; if ({rf_wen, busy1} !== 2'b00) $display("FAIL life_c6: got wen %0b busy %0b want 0 0", rf_wen, busy1); else pass_cnt++;
    endtask

    task automatic test_saturation;
        reserve(5'd7); reserve(5'd7); reserve(5'd7);
        issue_valid = 1'b1; issue_waddr = 5'd7;
        alu_valid = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'h77; settle();
        total_cnt++; if (issue_ready !== 1'b0) $display("FAIL sat_full: got %0b want 0", issue_ready); else pass_cnt++;
        tick();
        alu_valid = 1'b0; settle();
        total_cnt++; if ({rf_wen, rf_waddr, issue_ready} !== {1'b1, 5'd7, 1'b1}) $display("FAIL sat_retire_same_cycle: got wen %0b addr %0d ready %0b want 1 7 1", rf_wen, rf_waddr, issue_ready); else pass_cnt++;
        tick(); settle();
        total_cnt++; if (issue_ready !== 1'b0) $display("FAIL sat_still_full: got %0b want 0", issue_ready); else pass_cnt++;
        issue_valid = 1'b0;
        raddr1 = 5'd7;
        alu_valid = 1'b1;
        tick(); tick(); tick();
        alu_valid = 1'b0;
        tick(); settle();
        total_cnt++; if (busy1 !== 1'b0) $display("FAIL sat_drain: got %0b want 0", busy1); else pass_cnt++;
    endtask

    task automatic test_simultaneous;
        reserve(5'd9);
        alu_valid = 1'b1; alu_waddr = 5'd9; alu_wdata = 32'h99;
        tick();
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_waddr = 5'd9; settle();
        total_cnt++; if ({rf_wen, rf_waddr, issue_ready} !== {1'b1, 5'd9, 1'b1}) $display("FAIL simul_setup: got wen %0b addr %0d ready %0b want 1 9 1", rf_wen, rf_waddr, issue_ready); else pass_cnt++;
        tick();
        issue_valid = 1'b0; raddr1 = 5'd9; settle();
        total_cnt++; if (busy1 !== 1'b1) $display("FAIL simul_busy_held: got %0b want 1", busy1); else pass_cnt++;
        alu_valid = 1'b1;
        tick();
        alu_valid = 1'b0;
        tick(); settle();
        total_cnt++; if (busy1 !== 1'b0) $display("FAIL simul_cnt_was_one: got %0b want 0", busy1); else pass_cnt++;
    endtask

    task automatic test_midreset;
        logic bad;
        reserve(5'd10); reserve(5'd11);
        raddr1 = 5'd10; raddr2 = 5'd11;
        alu_valid = 1'b1; alu_waddr = 5'd10; alu_wdata = 32'hA;
        mem_valid = 1'b1; mem_waddr = 5'd11; mem_wdata = 32'hB; settle();
        total_cnt++; if ({alu_ready, mem_ready, busy1, busy2} !== 4'b0111) $display("FAIL mid_pre: got %0b want 0111", {alu_ready, mem_ready, busy1, busy2}); else pass_cnt++;
        tick();
        total_cnt++; if ({rf_wen, rf_waddr} !== {1'b1, 5'd11}) $display("FAIL mid_inflight: got %0b/%0d want 1/11", rf_wen, rf_waddr); else pass_cnt++;
        rst = 1'b0; settle();
        total_cnt++; if ({rf_wen, busy1, busy2} !== 3'b000) $display("FAIL mid_async: got %0b want 000", {rf_wen, busy1, busy2}); else pass_cnt++;
        tick();
        bad = 1'b0;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a); settle();
            if (busy1 !== 1'b0 || busy2 !== 1'b0 || rf_wen !== 1'b0) bad = 1'b1;
        end
        total_cnt++; if (bad !== 1'b0) $display("FAIL mid_all_clear: got busy/wen set under reset want all 0"); else pass_cnt++;
        mem_valid = 1'b0; rst = 1'b1; settle();
        total_cnt++; if (alu_ready !== 1'b1) $display("FAIL mid_post_ready: got %0b want 1", alu_ready); else pass_cnt++;
        alu_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        alu_valid = 1'b0; alu_waddr = 5'd0; alu_wdata = 32'd0;
        mem_valid = 1'b0; mem_waddr = 5'd0; mem_wdata = 32'd0;
        issue_valid = 1'b0; issue_waddr = 5'd0;
        raddr1 = 5'd0; raddr2 = 5'd0;
        test_reset();
        test_contention();
        test_zero_reg();
        test_lifecycle();
        test_saturation();
        test_simultaneous();
        test_midreset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: ALU (req 0) and load unit (req 1).
- Round-robin arbitration on valid/ready handshakes; the winner is registered onto the regfile wen/waddr/wdata pins.
- Keeps a per-register pending-write scoreboard so the issue stage can detect RAW hazards on both read ports.

Parameters:
- DATA_WIDTH, 32, writeback data width
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers)
- CNT_W, 2, per-register pending-write counter width; saturates at 2**CNT_W-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_waddr  in  ADDR_WIDTH  ALU destination
- alu_wdata  in  DATA_WIDTH  ALU result
- mem_valid / mem_ready / mem_waddr / mem_wdata: same as ALU, for the load unit
- issue_valid  in  1  issue stage reserves a destination
- issue_waddr  in  ADDR_WIDTH  reserved destination
- issue_ready  out  1  reservation can be accepted
- rf_wen  out  1  to regfile write enable
- rf_waddr  out  ADDR_WIDTH  to regfile write address
- rf_wdata  out  DATA_WIDTH  to regfile write data
- raddr1, raddr2  in  ADDR_WIDTH  issue-stage source addresses
- busy1, busy2  out  1  source has a pending write

Behaviour:
- Reset (rst=0, async): rf_wen=0, rf_waddr=0, rf_wdata=0, all counters=0, last_grant=1 (ALU wins first contention). Combinational outputs follow from the reset state.
- Handshake: a transfer occurs when valid&&ready. ready is combinational from the valids and last_grant. It never depends on the requester's own ready. Requesters hold valid/addr/data stable until accepted.
- Arbitration, one grant per cycle:
  - Only one valid: grant it.
  - Both valid: grant the one not equal to last_grant.
  - last_grant updates only on a grant.
  - No valid: no grant, last_grant holds.
- Output stage:
  - A grant in cycle N drives rf_wen=1 with the granted waddr/wdata in cycle N+1 (1-cycle latency).
  - The output stage always accepts (the regfile never stalls), so arbitration alone limits throughput.
  - Without a grant, rf_wen=0 next cycle. rf_waddr/rf_wdata hold their last values.
- Register 0:
  - A request with waddr=0 is accepted normally but produces rf_wen=0.
  - Reservations of 0 are ignored (issue_ready=1, no count).
  - busy for addr 0 is always 0.
- Scoreboard:
  - cnt[a] increments on issue_valid&&issue_ready for a=issue_waddr≠0.
  - cnt[a] decrements on the clock edge ending a cycle where rf_wen=1 and rf_waddr=a.
  - Increment and decrement of the same register in the same cycle: cnt unchanged.
  - issue_ready=0 when cnt[issue_waddr] is saturated and no decrement of that register happens this cycle.
  - A decrement at 0 is a protocol error: cnt stays 0 and it is flagged by a simulation assertion.
- Hazard outputs:
  - busyK = (cnt[raddrK]≠0), combinational.
  - busy deasserts in the cycle after the rf_wen cycle, the same cycle the regfile read returns the new value. No bypass.
- Reset mid-operation: in-flight output write dropped (rf_wen=0 immediately), scoreboard cleared, pending requests must be re-presented after rst returns to 1.

Decomposition:
- Shared package: DATA_WIDTH, ADDR_WIDTH, CNT_W, requester IDs REQ_ALU=0 / REQ_MEM=1, REG_ZERO=0.
- Sub-module reg_scoreboard: counter array, inc/dec/saturation, issue_ready and busy1/busy2.
- The top holds the arbiter and output register.

Test Plan:
- Reset: drive rst=0 mid-stream with both valids high -> rf_wen=0, busy1=busy2=0 for all raddr, alu_ready=1 once rst=1 with alu_valid=1 alone.
- Contention: both valid every cycle from reset, alu_waddr=3/0x11, mem_waddr=4/0x22 -> grants alternate ALU,MEM,ALU; rf_wen=1 each cycle with waddr sequence 3,4,3 starting one cycle after first grant.
- Zero register: alu_valid with waddr=0, wdata=0xDEAD -> alu_ready=1, rf_wen stays 0; issue reserve of 0 -> busy for raddr1=0 stays 0.
- Scoreboard lifecycle: reserve r5 at cycle 0, raddr1=5 -> busy1=1 from cycle 1; ALU write r5 granted cycle 4 -> rf_wen cycle 5, busy1=0 at cycle 6.
- Saturation: reserve r7 three times (CNT_W=2) -> issue_ready=0 on the fourth attempt; the same cycle a r7 rf_wen occurs -> issue_ready=1, cnt stays 3.
- Simultaneous: reserve r9 in the same cycle rf_wen writes r9 with cnt=1 -> cnt stays 1, busy1 (raddr1=9) remains 1.
